sbox_word_arbiter: RTL and testbench

// - Shares the single 32-bit SubWord unit (4 parallel S-box bytes) between key expansion (KX) and cipher SubBytes datapath (DP).
// - Sits between both requesters and the S-box: muxes the granted word onto sbox_in, tags it, returns sbox_out to its owner after SBOX_LAT cycles.
// - Round-robin per word; DP may lock the unit for a 4-word state burst, capped at LOCK_MAX grants.

---
 rtl/aes_pkg.sv | 15 +
 rtl/sbox_tag_pipe.sv | 41 ++++
 rtl/sbox_word_arbiter.sv | 117 +++++++++++
 tb/tb_sbox_word_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES S-box word arbiter: datapath width,
// requester IDs and arbiter FSM states.
package aes_pkg;

    localparam int WORD_W = 32;

    localparam logic REQ_KX = 1'b0;
    localparam logic REQ_DP = 1'b1;

    typedef enum logic {
        ARB     = 1'b0,
        LOCK_DP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sbox_tag_pipe.sv
// Delay line for {valid, owner} tags that tracks words through the shared
// S-box. LAT = 0 degenerates to a wire for a combinational S-box.
module sbox_tag_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner
);

    generate
        if (LAT == 0) begin : g_pass
            assign out_valid = in_valid;
            assign out_owner = in_owner;
        end else begin : g_pipe
            logic [LAT-1:0] valid_q;
            logic [LAT-1:0] owner_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= '0;
                    owner_q <= '0;
                end else begin
                    valid_q[0] <= in_valid;
                    owner_q[0] <= in_owner;
                    for (int i = 1; i < LAT; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        owner_q[i] <= owner_q[i-1];
                    end
                end
            end

            assign out_valid = valid_q[LAT-1];
            assign out_owner = owner_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/sbox_word_arbiter.sv
// Shares one SubWord S-box unit between key expansion (KX) and the cipher
// datapath (DP): round-robin per word, with a bounded DP lock for bursts.
module sbox_word_arbiter #(
    parameter int WORD_W   = 32,
    parameter int SBOX_LAT = 1,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              kx_req,
    input  logic [WORD_W-1:0] kx_din,
    output logic              kx_gnt,
    output logic              kx_vld,
    output logic [WORD_W-1:0] kx_dout,
    input  logic              dp_req,
    input  logic [WORD_W-1:0] dp_din,
    input  logic              dp_lock,
    output logic              dp_gnt,
    output logic              dp_vld,
    output logic [WORD_W-1:0] dp_dout,
    output logic [WORD_W-1:0] sbox_in,
    input  logic [WORD_W-1:0] sbox_out
);

    import aes_pkg::*;

    localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_MAX);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              rr;
    logic              rr_next;
    logic [3:0]        lock_cnt;
    logic [3:0]        lock_cnt_next;
    logic [WORD_W-1:0] sbox_last;
    logic              tag_valid;
    logic              tag_owner;

    // rr holds the requester ID that wins when both request in ARB.
    always_comb begin
        kx_gnt        = 1'b0;
        dp_gnt        = 1'b0;
        state_next    = state;
        rr_next       = rr;
        lock_cnt_next = lock_cnt;

        if (!reset) begin
            case (state)
                ARB: begin
                    if (kx_req && (!dp_req || rr == REQ_KX)) begin
                        kx_gnt = 1'b1;
                    end else if (dp_req) begin
                        dp_gnt = 1'b1;
                    end
                end
                LOCK_DP: dp_gnt = dp_req;
                default: ;
            endcase
        end

        if (kx_gnt) rr_next = REQ_DP;
        if (dp_gnt) rr_next = REQ_KX;

        case (state)
            ARB: begin
                if (dp_gnt && dp_lock && LOCK_MAX > 1) begin
                    state_next    = LOCK_DP;
                    lock_cnt_next = 4'd1;
                end
            end
            LOCK_DP: begin
                if (!dp_lock || (dp_gnt && (lock_cnt + 4'd1) == LOCK_LIMIT)) begin
                    state_next    = ARB;
                    lock_cnt_next = 4'd0;
                    rr_next       = REQ_KX;
                end else if (dp_gnt) begin
                    lock_cnt_next = lock_cnt + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB;
            rr        <= REQ_KX;
            lock_cnt  <= 4'd0;
            sbox_last <= '0;
        end else begin
            state     <= state_next;
            rr        <= rr_next;
            lock_cnt  <= lock_cnt_next;
            sbox_last <= sbox_in;
        end
    end

    // Idle cycles replay the last word so the S-box inputs do not toggle.
    assign sbox_in = kx_gnt ? kx_din : (dp_gnt ? dp_din : sbox_last);

    sbox_tag_pipe #(
        .LAT (SBOX_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (kx_gnt | dp_gnt),
        .in_owner  (dp_gnt ? REQ_DP : REQ_KX),
        .out_valid (tag_valid),
        .out_owner (tag_owner)
    );

    assign kx_vld  = tag_valid && !reset && (tag_owner == REQ_KX);
    assign dp_vld  = tag_valid && !reset && (tag_owner == REQ_DP);
    assign kx_dout = kx_vld ? sbox_out : '0;
    assign dp_dout = dp_vld ? sbox_out : '0;

endmodule

// File: tb/tb_sbox_word_arbiter.sv
// Bench for sbox_word_arbiter: reference S-box built from GF(2^8) inverses,
// scoreboard of granted words against delivered results, directed scenarios.
module tb_sbox_word_arbiter;

    localparam int W    = 32;
    localparam int LAT  = 2;
    localparam int LMAX = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         kx_req = 1'b0, dp_req = 1'b0, dp_lock = 1'b0;
    logic [W-1:0] kx_din = '0, dp_din = '0;
    logic         kx_gnt, kx_vld, dp_gnt, dp_vld;
    logic [W-1:0] kx_dout, dp_dout, sbox_in, sbox_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] sbox_tab [256];

    typedef struct {
        logic         owner;
        logic [W-1:0] data;
        int           due;
    } exp_t;
    exp_t sb[$];

    sbox_word_arbiter #(.WORD_W(W), .SBOX_LAT(LAT), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .reset(reset),
        .kx_req(kx_req), .kx_din(kx_din), .kx_gnt(kx_gnt), .kx_vld(kx_vld), .kx_dout(kx_dout),
        .dp_req(dp_req), .dp_din(dp_din), .dp_lock(dp_lock), .dp_gnt(dp_gnt), .dp_vld(dp_vld),
        .dp_dout(dp_dout), .sbox_in(sbox_in), .sbox_out(sbox_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [W-1:0] subword(input logic [W-1:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    // External S-box model: registered, LAT stages deep.
    logic [W-1:0] sq [LAT];
    always @(posedge clk) begin
        sq[0] <= subword(sbox_in);
        for (int i = 1; i < LAT; i++) sq[i] <= sq[i-1];
    end
    assign sbox_out = sq[LAT-1];

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (kx_gnt && dp_gnt) begin
                n_checks++; n_fail++;
                $display("FAIL dual_grant cycle=%0d got kx_gnt=1 dp_gnt=1 exp at most one", cyc);
            end
            if ((kx_gnt && !kx_req) || (dp_gnt && !dp_req)) begin
                n_checks++; n_fail++;
                $display("FAIL grant_without_req cycle=%0d got kx=%b/%b dp=%b/%b (gnt/req)",
                         cyc, kx_gnt, kx_req, dp_gnt, dp_req);
            end
            if (kx_gnt) sb.push_back('{1'b0, subword(kx_din), cyc + LAT});
            if (dp_gnt) sb.push_back('{1'b1, subword(dp_din), cyc + LAT});
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.owner == 1'b0) begin
                    if (kx_vld !== 1'b1 || dp_vld !== 1'b0 || kx_dout !== e.data) begin
                        n_fail++;
                        $display("FAIL kx_result cycle=%0d got vld=%b/%b dout=%h exp vld=1/0 dout=%h",
                                 cyc, kx_vld, dp_vld, kx_dout, e.data);
                    end
                end else begin
                    if (dp_vld !== 1'b1 || kx_vld !== 1'b0 || dp_dout !== e.data) begin
                        n_fail++;
                        $display("FAIL dp_result cycle=%0d got vld=%b/%b dout=%h exp vld=1/0 dout=%h",
                                 cyc, dp_vld, kx_vld, dp_dout, e.data);
                    end
                end
            end else if (kx_vld || dp_vld) begin
                n_checks++; n_fail++;
                $display("FAIL spurious_vld cycle=%0d got kx_vld=%b dp_vld=%b exp 0/0", cyc, kx_vld, dp_vld);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (kx_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_kx_gnt got=%b exp=0", kx_gnt); end
        n_checks++; if (dp_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_dp_gnt got=%b exp=0", dp_gnt); end
        n_checks++; if (kx_vld !== 1'b0 || dp_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b%b exp=00", kx_vld, dp_vld); end
        n_checks++; if (kx_dout !== '0) begin n_fail++; $display("FAIL reset_kx_dout got=%h exp=0", kx_dout); end
        n_checks++; if (dp_dout !== '0) begin n_fail++; $display("FAIL reset_dp_dout got=%h exp=0", dp_dout); end
        n_checks++; if (sbox_in !== '0) begin n_fail++; $display("FAIL reset_sbox_in got=%h exp=0", sbox_in); end
        tick();
    endtask

    task automatic test_alternate();
        logic exp_kx;
        kx_req = 1'b1; dp_req = 1'b1; kx_din = $urandom; dp_din = $urandom;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_kx = (i % 2 == 0);
            n_checks++;
            if (kx_gnt !== exp_kx || dp_gnt !== !exp_kx) begin
                n_fail++;
                $display("FAIL alternate[%0d] got kx/dp=%b%b exp=%b%b", i, kx_gnt, dp_gnt, exp_kx, !exp_kx);
            end
            tick();
            if (exp_kx) kx_din = $urandom; else dp_din = $urandom;
        end
        kx_req = 1'b0; dp_req = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    task automatic test_single_kx();
        logic [W-1:0] exp;
        kx_req = 1'b1; kx_din = 32'h09cf4f3c;
        exp = subword(kx_din);
        @(negedge clk);
        n_checks++; if (kx_gnt !== 1'b1 || dp_gnt !== 1'b0) begin n_fail++; $display("FAIL single_gnt got kx/dp=%b%b exp=10", kx_gnt, dp_gnt); end
        n_checks++; if (sbox_in !== 32'h09cf4f3c) begin n_fail++; $display("FAIL single_sbox_in got=%h exp=09cf4f3c", sbox_in); end
        for (int k = 0; k <= LAT; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++;
            if (kx_vld !== (k == LAT)) begin n_fail++; $display("FAIL single_vld_t%0d got=%b exp=%b", k, kx_vld, (k == LAT)); end
            if (k == LAT) begin
                n_checks++;
                if (kx_dout !== exp || dp_vld !== 1'b0) begin n_fail++; $display("FAIL single_dout got=%h dp_vld=%b exp=%h dp_vld=0", kx_dout, dp_vld, exp); end
            end
            if (k == 0) begin tick(); kx_req = 1'b0; end
        end
        n_checks++; if (sbox_in !== 32'h09cf4f3c) begin n_fail++; $display("FAIL idle_sbox_hold got=%h exp=09cf4f3c", sbox_in); end
        tick();
    endtask

    task automatic test_lock();
        logic [9:0] pat = 10'b0111101111;
        int wait_cnt = 0;
        kx_req = 1'b1; dp_req = 1'b1; dp_lock = 1'b1; kx_din = $urandom; dp_din = $urandom;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wait_cnt++;
            n_checks++;
            if (dp_gnt !== pat[i] || kx_gnt !== !pat[i]) begin
                n_fail++;
                $display("FAIL lock_seq[%0d] got kx/dp=%b%b exp=%b%b", i, kx_gnt, dp_gnt, !pat[i], pat[i]);
            end
            if (kx_gnt) begin
                n_checks++;
                if (wait_cnt > LMAX + 1) begin n_fail++; $display("FAIL kx_wait got=%0d exp<=%0d", wait_cnt, LMAX + 1); end
                wait_cnt = 0;
            end
            tick();
            if (kx_gnt === 1'b0 && pat[i]) dp_din = $urandom; else kx_din = $urandom;
        end
        kx_req = 1'b0; dp_req = 1'b0; dp_lock = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    task automatic test_lock_drop();
        logic [3:0] pat = 4'b1011;
        kx_req = 1'b1; dp_req = 1'b1; dp_lock = 1'b1; kx_din = $urandom; dp_din = $urandom;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (dp_gnt !== pat[i] || kx_gnt !== !pat[i]) begin
                n_fail++;
                $display("FAIL lock_drop[%0d] got kx/dp=%b%b exp=%b%b", i, kx_gnt, dp_gnt, !pat[i], pat[i]);
            end
            tick();
            dp_lock = 1'b0;
            if (pat[i]) dp_din = $urandom; else kx_din = $urandom;
        end
        kx_req = 1'b0; dp_req = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    task automatic test_reset_inflight();
        kx_req = 1'b1; kx_din = $urandom;
        tick();
        kx_req = 1'b0; dp_req = 1'b1; dp_lock = 1'b1; dp_din = $urandom;
        tick();
        dp_req = 1'b0; reset = 1'b1; sb.delete();
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (kx_vld !== 1'b0 || dp_vld !== 1'b0) begin n_fail++; $display("FAIL post_reset_vld[%0d] got=%b%b exp=00", i, kx_vld, dp_vld); end
            tick();
        end
        kx_req = 1'b1; dp_req = 1'b1; kx_din = $urandom; dp_din = $urandom;
        @(negedge clk);
        n_checks++;
        if (kx_gnt !== 1'b1 || dp_gnt !== 1'b0) begin n_fail++; $display("FAIL post_reset_first got kx/dp=%b%b exp=10", kx_gnt, dp_gnt); end
        tick();
        kx_req = 1'b0;
        @(negedge clk);
        tick();
        dp_req = 1'b0; dp_lock = 1'b0;
        repeat (LAT + 2) tick();
    endtask

    task automatic test_key_schedule();
        logic [W-1:0] w [44];
        logic [7:0]   rcon [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        logic [W-1:0] gold [4] = '{32'h13111d7f, 32'he3944a17, 32'hf307a78b, 32'h4d2b30c5};
        logic         bg_run = 1'b1;
        w[0] = 32'h00010203; w[1] = 32'h04050607; w[2] = 32'h08090a0b; w[3] = 32'h0c0d0e0f;
        for (int i = 4; i < 44; i++) w[i] = '0;
        fork
            begin
                logic [W-1:0] temp, sub;
                logic got, granted, aborted;
                int n;
                aborted = 1'b0;
                for (int i = 4; i < 44 && !aborted; i++) begin
                    temp = w[i-1];
                    if (i % 4 == 0) begin
                        kx_req = 1'b1; kx_din = {temp[23:0], temp[31:24]};
                        granted = 1'b0; n = 0;
                        while (!granted && n < LMAX + 1) begin
                            @(negedge clk); n++; granted = kx_gnt;
                        end
                        got = kx_vld; sub = kx_dout;
                        n_checks++;
                        if (!granted) begin
                            n_fail++; aborted = 1'b1;
                            $display("FAIL ks_kx_wait word=%0d got no grant in %0d cycles exp<=%0d", i, n, LMAX + 1);
                        end
                        tick();
                        kx_req = 1'b0;
                        n = 0;
                        while (granted && !got && n < LAT + 2) begin
                            @(negedge clk); n++; got = kx_vld; sub = kx_dout;
                        end
                        if (granted && !got) begin
                            n_checks++; n_fail++; aborted = 1'b1;
                            $display("FAIL ks_kx_vld word=%0d got no vld in %0d cycles exp %0d", i, n, LAT);
                        end
                        if (n > 0) tick();
                        temp = sub ^ {rcon[i/4-1], 24'h0};
                    end
                    w[i] = w[i-4] ^ temp;
                end
                bg_run = 1'b0;
            end
            begin
                logic g;
                while (bg_run) begin
                    @(negedge clk); g = dp_gnt;
                    @(posedge clk); #1;
                    if (g || !dp_req) begin
                        dp_req  = ($urandom_range(0, 3) != 0);
                        dp_din  = $urandom;
                        dp_lock = dp_req & ($urandom_range(0, 1) == 1);
                    end
                end
                dp_req = 1'b0; dp_lock = 1'b0;
            end
        join
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (w[40+k] !== gold[k]) begin n_fail++; $display("FAIL ks_w%0d got=%h exp=%h", 40 + k, w[40+k], gold[k]); end
        end
        repeat (LAT + 3) tick();
    endtask

    initial begin
        logic [7:0] inv, s;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int u = 1; u < 256; u++) if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_tab[v] = s;
        end
        test_reset();
        test_alternate();
        test_single_kx();
        test_lock();
        test_lock_drop();
        test_reset_inflight();
        test_key_schedule();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL drain got=%0d pending exp=0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
